// File: rtl/servo_pwm_array_if.sv
// APB3 bus bundle for the servo PWM array: master drives the request side,
// slave returns read data, ready and error.
interface servo_pwm_array_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/servo_pwm_array.sv
// APB3 servo PWM array: NUM_CH channels sharing one period counter, double-buffered
// clamped pulse widths. Define SERVO_SLEW_EN to rate-limit active widths per period.
module servo_pwm_array #(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 32,
   parameter int DEF_PERIOD = 2000000,
   parameter int DEF_PULSE  = 150000,
   parameter int MIN_PULSE  = 100000,
   parameter int MAX_PULSE  = 200000,
   parameter int DEF_SLEW   = 1000
) (
   input  logic               PCLK,
   input  logic               PRESET,
   servo_pwm_array_if.slave   apb,
   output logic [NUM_CH-1:0]  pwm_out
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]            ctrl_reg;
   logic [CNT_W-1:0]             period_reg;
   logic [CNT_W-1:0]             count_reg;
   logic [CNT_W-1:0]             slew_val;
   logic [NUM_CH-1:0][CNT_W-1:0] target_vec;
   logic [NUM_CH-1:0][CNT_W-1:0] active_vec;

   logic [11:0]      addr;
   logic [5:0]       ch_idx;
   logic [CH_W-1:0]  ch_sel;
   logic             dec_err;
   logic             ro_hit;
   logic             period_bad;
   logic             perr;
   logic             access;
   logic             wr_en;
   logic             wr_tgt;
   logic             wrap;
   logic [31:0]      rdata;
   logic [31:0]      wdata_clamp;
   logic [CNT_W-1:0] wdata_cnt;
   logic             unused_addr_bits;

   assign addr             = apb.PADDR[11:0];
   assign ch_idx           = addr[7:2];
   assign ch_sel           = ch_idx[CH_W-1:0];
   assign unused_addr_bits = ^apb.PADDR[31:12];

   always_comb begin
      dec_err = 1'b0;
      ro_hit  = 1'b0;
      rdata   = '0;
      if (addr[1:0] != 2'b00) begin
         dec_err = 1'b1;
      end else if (addr[11:8] == 4'h0) begin
         case (addr[7:0])
            8'h00:   rdata = 32'(ctrl_reg);
            8'h04:   rdata = 32'(period_reg);
            8'h08:   rdata = 32'(slew_val);
            8'h0C: begin
               rdata  = 32'(count_reg);
               ro_hit = 1'b1;
            end
            default: dec_err = 1'b1;
         endcase
      end else if (addr[11:8] == 4'h1 || addr[11:8] == 4'h2) begin
         // Channel windows: 0x1xx targets (RW), 0x2xx active widths (RO)
         if (ch_idx >= 6'(NUM_CH)) begin
            dec_err = 1'b1;
         end else begin
            rdata  = addr[9] ? 32'(active_vec[ch_sel]) : 32'(target_vec[ch_sel]);
            ro_hit = addr[9];
         end
      end else begin
         dec_err = 1'b1;
      end
   end

   assign period_bad = (addr == 12'h004) && (apb.PWDATA < 32'd2);
   assign perr       = dec_err | (apb.PWRITE & (ro_hit | period_bad));
   assign access     = apb.PSEL & apb.PENABLE;
   assign wr_en      = access & apb.PWRITE & ~perr;
   assign wr_tgt     = wr_en & (addr[11:8] == 4'h1);

   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = access & perr;
   assign apb.PRDATA  = (apb.PSEL & ~apb.PWRITE & ~perr) ? rdata : 32'd0;

   always_comb begin
      if (apb.PWDATA < 32'(MIN_PULSE))
         wdata_clamp = 32'(MIN_PULSE);
      else if (apb.PWDATA > 32'(MAX_PULSE))
         wdata_clamp = 32'(MAX_PULSE);
      else
         wdata_clamp = apb.PWDATA;
   end

   assign wdata_cnt = CNT_W'(apb.PWDATA);

   // Compare against the live period so a shrinking PERIOD wraps at once
   assign wrap = (count_reg >= period_reg - CNT_W'(1));

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         ctrl_reg   <= '0;
         period_reg <= CNT_W'(DEF_PERIOD);
         count_reg  <= '0;
      end else begin
         count_reg <= wrap ? '0 : count_reg + CNT_W'(1);
         if (wr_en && addr == 12'h000)
            ctrl_reg <= apb.PWDATA[NUM_CH-1:0];
         if (wr_en && addr == 12'h004)
            period_reg <= wdata_cnt;
      end
   end

`ifdef SERVO_SLEW_EN
   logic [CNT_W-1:0] slew_reg;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)
         slew_reg <= CNT_W'(DEF_SLEW);
      else if (wr_en && addr == 12'h008)
         slew_reg <= wdata_cnt;
   end

   assign slew_val = slew_reg;
`else
   assign slew_val = '0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [CNT_W-1:0] target_reg;
         logic [CNT_W-1:0] active_reg;
         logic [CNT_W-1:0] active_next;
         logic             pwm_reg;

`ifdef SERVO_SLEW_EN
         logic [CNT_W-1:0] diff;
         logic [CNT_W-1:0] step;

         assign diff        = (target_reg > active_reg) ? target_reg - active_reg
                                                        : active_reg - target_reg;
         assign step        = (diff < slew_val) ? diff : slew_val;
         assign active_next = (target_reg > active_reg) ? active_reg + step
                                                        : active_reg - step;
`else
         assign active_next = target_reg;
`endif

         always_ff @(posedge PCLK or posedge PRESET) begin
            if (PRESET) begin
               target_reg <= CNT_W'(DEF_PULSE);
               active_reg <= CNT_W'(DEF_PULSE);
               pwm_reg    <= 1'b0;
            end else begin
               if (wr_tgt && ch_sel == CH_W'(gi))
                  target_reg <= CNT_W'(wdata_clamp);
               if (wrap)
                  active_reg <= active_next;
               pwm_reg <= ctrl_reg[gi] & (count_reg < active_reg);
            end
         end

         assign target_vec[gi] = target_reg;
         assign active_vec[gi] = active_reg;
         assign pwm_out[gi]    = pwm_reg;
      end
   endgenerate

endmodule

// File: tb/tb_servo_pwm_array.sv
// Directed + randomized bench for servo_pwm_array against a cycle-level behavioural model.
module tb_servo_pwm_array;
   localparam int NUM_CH     = 4;
   localparam int DEF_PERIOD = 100;
   localparam int DEF_PULSE  = 30;
   localparam int MIN_P      = 10;
   localparam int MAX_P      = 60;
   localparam int DEF_SLEW   = 5;
`ifdef SERVO_SLEW_EN
   localparam bit SLEW_ON = 1'b1;
`else
   localparam bit SLEW_ON = 1'b0;
`endif

   logic              PCLK = 1'b0;
   logic              PRESET;
   logic [NUM_CH-1:0] pwm_out;

   servo_pwm_array_if bus ();

   servo_pwm_array #(
      .NUM_CH(NUM_CH), .CNT_W(32), .DEF_PERIOD(DEF_PERIOD), .DEF_PULSE(DEF_PULSE),
      .MIN_PULSE(MIN_P), .MAX_PULSE(MAX_P), .DEF_SLEW(DEF_SLEW)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .apb(bus), .pwm_out(pwm_out)
   );

   always #5 PCLK = ~PCLK;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   int                m_count, m_period, m_ctrl, m_slew;
   int                m_target [NUM_CH];
   int                m_active [NUM_CH];
   logic [NUM_CH-1:0] m_pwm;

   int rand_addrs [13] = '{'h000, 'h004, 'h008, 'h00C, 'h100, 'h104, 'h10C, 'h110,
                           'h200, 'h20C, 'h210, 'h300, 'h002};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      m_count  = 0;
      m_period = DEF_PERIOD;
      m_ctrl   = 0;
      m_slew   = DEF_SLEW;
      m_pwm    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         m_target[i] = DEF_PULSE;
         m_active[i] = DEF_PULSE;
      end
   endfunction

   function automatic void m_decode(input logic [31:0] addr, input bit wr,
                                    input logic [31:0] data, output bit err, output int rd);
      int a;
      a   = int'(addr[11:0]);
      err = 1'b0;
      rd  = 0;
      if (a % 4 != 0) err = 1'b1;
      else if (a == 'h000) rd = m_ctrl;
      else if (a == 'h004) begin rd = m_period; if (wr && data < 2) err = 1'b1; end
      else if (a == 'h008) rd = SLEW_ON ? m_slew : 0;
      else if (a == 'h00C) begin rd = m_count; if (wr) err = 1'b1; end
      else if (a >= 'h100 && a < 'h100 + 4*NUM_CH) rd = m_target[(a - 'h100) / 4];
      else if (a >= 'h200 && a < 'h200 + 4*NUM_CH) begin
         rd = m_active[(a - 'h200) / 4];
         if (wr) err = 1'b1;
      end
      else err = 1'b1;
      if (err) rd = 0;
   endfunction

   function automatic void m_write(input logic [31:0] addr, input logic [31:0] data);
      int a;
      int d;
      a = int'(addr[11:0]);
      d = int'(data);
      if (a == 'h000) m_ctrl = d & ((1 << NUM_CH) - 1);
      else if (a == 'h004) m_period = d;
      else if (a == 'h008) begin if (SLEW_ON) m_slew = d; end
      else if (a >= 'h100 && a < 'h200)
         m_target[(a - 'h100) / 4] = (d < MIN_P) ? MIN_P : (d > MAX_P) ? MAX_P : d;
   endfunction

   // One clock edge of the model, using the bus values present at that edge
   function automatic void m_edge();
      bit err;
      int rd, d, mag, st;
      for (int i = 0; i < NUM_CH; i++)
         m_pwm[i] = ((m_ctrl >> i) & 1) == 1 && m_count < m_active[i];
      if (m_count >= m_period - 1) begin
         m_count = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (SLEW_ON) begin
               d   = m_target[i] - m_active[i];
               mag = (d < 0) ? -d : d;
               st  = (mag < m_slew) ? mag : m_slew;
               m_active[i] = m_active[i] + ((d < 0) ? -st : st);
            end else begin
               m_active[i] = m_target[i];
            end
         end
      end else begin
         m_count++;
      end
      if (bus.PSEL && bus.PENABLE && bus.PWRITE) begin
         m_decode(bus.PADDR, 1'b1, bus.PWDATA, err, rd);
         if (!err) m_write(bus.PADDR, bus.PWDATA);
      end
   endfunction

   task automatic tick();
      @(posedge PCLK);
      if (PRESET) m_reset();
      else        m_edge();
      #1;
      check("pwm", 32'(pwm_out), 32'(m_pwm));
   endtask

   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output bit err);
      bit m_err;
      int m_rd;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
      bus.PADDR = addr; bus.PWDATA = data;
      tick();
      bus.PENABLE = 1'b1;
      #1;
      m_decode(addr, 1'b1, data, m_err, m_rd);
      err = bus.PSLVERR;
      check($sformatf("wr_err@%0h", addr), 32'(bus.PSLVERR), 32'(m_err));
      $display("apb write addr=%03h data=%0d pslverr=%0d", addr[11:0], data, bus.PSLVERR);
      tick();
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] addr, output logic [31:0] rd, output bit err);
      bit m_err;
      int m_rd;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = addr;
      tick();
      bus.PENABLE = 1'b1;
      #1;
      m_decode(addr, 1'b0, 32'd0, m_err, m_rd);
      rd  = bus.PRDATA;
      err = bus.PSLVERR;
      check($sformatf("rd_err@%0h", addr), 32'(bus.PSLVERR), 32'(m_err));
      check($sformatf("rd_data@%0h", addr), bus.PRDATA, 32'(m_rd));
      $display("apb read  addr=%03h data=%0d pslverr=%0d", addr[11:0], bus.PRDATA, bus.PSLVERR);
      tick();
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
   endtask

   // Always advances at least one edge, stops right after the next wrap
   task automatic run_to_wrap();
      int g;
      g = 0;
      do begin
         tick();
         g++;
      end while (m_count != 0 && g < 300);
      check("wrap_reached", 32'(m_count), 32'd0);
   endtask

   logic [31:0] rd;
   bit          err;
   int          ones [NUM_CH];
   int          edges [3];
   int          n_edge;
   logic        prev;
   int          exp_ramp [5];

   initial begin
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus.PADDR = '0; bus.PWDATA = '0;
      PRESET = 1'b1;
      m_reset();
      repeat (2) @(posedge PCLK);
      #1;
      check("reset_pwm", 32'(pwm_out), 32'd0);
      check("reset_prdata", bus.PRDATA, 32'd0);
      check("reset_pslverr", 32'(bus.PSLVERR), 32'd0);
      PRESET = 1'b0;

      apb_read(32'h004, rd, err);
      check("reset_period", rd, 32'd100);
      apb_read(32'h200, rd, err);
      check("reset_active0", rd, 32'd30);

      // all channels on: 30 high cycles out of 100
      apb_write(32'h000, 32'hF, err);
      run_to_wrap();
      for (int i = 0; i < NUM_CH; i++) ones[i] = 0;
      repeat (100) begin
         tick();
         for (int i = 0; i < NUM_CH; i++) ones[i] += int'(pwm_out[i]);
      end
      for (int i = 0; i < NUM_CH; i++)
         check($sformatf("ch%0d_high", i), 32'(ones[i]), 32'd30);
      apb_read(32'h00C, rd, err);

      // TARGET[1] mid-period is buffered until the wrap
      repeat (40) tick();
      apb_write(32'h104, 32'd45, err);
      apb_read(32'h204, rd, err);
      check("active1_before_wrap", rd, 32'd30);
      run_to_wrap();
      ones[1] = 0;
      repeat (100) begin
         tick();
         ones[1] += int'(pwm_out[1]);
      end
      check("ch1_high_new", 32'(ones[1]), SLEW_ON ? 32'd35 : 32'd45);
      apb_read(32'h204, rd, err);

      // clamping
      apb_write(32'h108, 32'd5, err);
      check("clamp_lo_err", 32'(err), 32'd0);
      apb_read(32'h108, rd, err);
      check("clamp_lo", rd, 32'd10);
      apb_write(32'h108, 32'd99, err);
      apb_read(32'h108, rd, err);
      check("clamp_hi", rd, 32'd60);

      // error responses leave state alone
      apb_write(32'h110, 32'd40, err);
      check("err_ch4", 32'(err), 32'd1);
      apb_write(32'h00C, 32'd5, err);
      check("err_status_wr", 32'(err), 32'd1);
      apb_write(32'h004, 32'd1, err);
      check("err_period1", 32'(err), 32'd1);
      apb_write(32'h204, 32'd7, err);
      check("err_active_wr", 32'(err), 32'd1);
      apb_read(32'h300, rd, err);
      check("err_unmapped", 32'(err), 32'd1);
      apb_read(32'h004, rd, err);
      check("period_kept", rd, 32'd100);

      // shrink PERIOD while the count is already past it
      for (int g = 0; g < 300 && m_count != 69; g++) tick();
      apb_write(32'h004, 32'd50, err);
      apb_read(32'h00C, rd, err);
      check("status_after_shrink", rd, 32'd0);
      n_edge = 0;
      prev   = pwm_out[0];
      for (int t = 0; t < 400 && n_edge < 3; t++) begin
         tick();
         if (pwm_out[0] && !prev) begin
            edges[n_edge] = t;
            n_edge++;
         end
         prev = pwm_out[0];
      end
      check("edges_found", 32'(n_edge), 32'd3);
      check("period50_a", 32'(edges[1] - edges[0]), 32'd50);
      check("period50_b", 32'(edges[2] - edges[1]), 32'd50);

      // slew ramp on channel 0
      apb_write(32'h004, 32'd100, err);
      apb_write(32'h100, 32'd52, err);
      if (SLEW_ON) exp_ramp = '{35, 40, 45, 50, 52};
      else         exp_ramp = '{52, 52, 52, 52, 52};
      for (int k = 0; k < 5; k++) begin
         run_to_wrap();
         apb_read(32'h200, rd, err);
         check($sformatf("ramp%0d", k), rd, 32'(exp_ramp[k]));
      end
      apb_write(32'h008, 32'd7, err);
      check("slew_wr_err", 32'(err), 32'd0);
      apb_read(32'h008, rd, err);
      check("slew_rd", rd, SLEW_ON ? 32'd7 : 32'd0);

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 5))
            0: apb_write(32'h100 + 4 * $urandom_range(0, NUM_CH - 1), $urandom_range(0, 80), err);
            1: apb_write(32'h000, $urandom_range(0, 15), err);
            2: apb_write(32'h004, $urandom_range(0, 130), err);
            3: apb_write(32'h008, $urandom_range(0, 10), err);
            4: apb_read(rand_addrs[$urandom_range(0, 12)], rd, err);
            default: repeat ($urandom_range(1, 40)) tick();
         endcase
      end

      // asynchronous reset mid-pulse
      apb_write(32'h004, 32'd100, err);
      apb_write(32'h000, 32'hF, err);
      run_to_wrap();
      repeat (3) tick();
      check("pre_reset_high", 32'(pwm_out), 32'hF);
      #2 PRESET = 1'b1;
      #1;
      check("async_reset_pwm", 32'(pwm_out), 32'd0);
      tick();
      PRESET = 1'b0;
      apb_read(32'h000, rd, err);
      check("post_reset_ctrl", rd, 32'd0);
      apb_read(32'h104, rd, err);
      check("post_reset_target1", rd, 32'd30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
